// File: rtl/lcd_placar_writer.sv
// HD44780 8-bit write-only driver for the Pong score string: runs the power-up
// init, then writes the 4-character score to line 1, columns 0-3, on every strobe edge.
module lcd_placar_writer #(
  parameter int T_PWRUP = 750000,
  parameter int T_SETUP = 2,
  parameter int T_EN    = 25,
  parameter int T_CMD   = 2000,
  parameter int T_CLEAR = 82000
) (
  input  logic        clk_in,
  input  logic        i_rst,
  input  logic [31:0] placar_in,
  input  logic        placar_valid,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        busy,
  output logic        ready
);

  localparam int T_MAX_A = (T_PWRUP > T_CLEAR) ? T_PWRUP : T_CLEAR;
  localparam int T_MAX_B = (T_CMD > T_EN) ? T_CMD : T_EN;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int CW      = $clog2(T_MAX + 1);

  localparam logic [CW-1:0] PWRUP_LAST = CW'(T_PWRUP - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] EN_LAST    = CW'(T_EN - 1);
  localparam logic [CW-1:0] CMD_LAST   = CW'(T_CMD - 1);
  localparam logic [CW-1:0] CLEAR_LAST = CW'(T_CLEAR - 1);

  typedef enum logic [2:0] {S_PWRUP, S_INIT, S_IDLE, S_ADDR, S_CHAR} top_state_t;
  typedef enum logic [1:0] {W_IDLE, W_SETUP, W_PULSE, W_HOLD} wr_state_t;

  top_state_t    state;
  wr_state_t     wstate;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [31:0]   str_q;
  logic [31:0]   pend_q;
  logic          pending;
  logic          valid_q;

  logic          edge_det;
  logic          byte_done;
  logic          last_done;
  logic          load_byte;
  logic [7:0]    nxt_data;
  logic          nxt_rs;
  logic [CW-1:0] hold_last;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  // Byte 3 is the leftmost character; NUL renders as a space.
  function automatic logic [7:0] char_byte(input logic [31:0] s, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = s[31:24];
      2'd1:    b = s[23:16];
      2'd2:    b = s[15:8];
      default: b = s[7:0];
    endcase
    return (b == 8'h00) ? 8'h20 : b;
  endfunction

  assign lcd_rw    = 1'b0;
  assign edge_det  = placar_valid & ~valid_q;
  assign hold_last = (!lcd_rs && lcd_data == 8'h01) ? CLEAR_LAST : CMD_LAST;
  assign byte_done = (wstate == W_HOLD) && (cnt == hold_last);
  assign last_done = byte_done && (idx == 2'd3) && (state == S_INIT || state == S_CHAR);

  // NOTE: every output of always_comb gets a default first, otherwise paths
  // that skip an assignment infer a latch.
  always_comb begin
    load_byte = 1'b0;
    nxt_data  = 8'h00;
    nxt_rs    = 1'b0;
    case (state)
      S_PWRUP: begin
        load_byte = (cnt == PWRUP_LAST);
        nxt_data  = init_cmd(2'd0);
      end
      S_INIT: begin
        load_byte = byte_done && (idx != 2'd3);
        nxt_data  = init_cmd(idx + 2'd1);
      end
      S_IDLE: begin
        load_byte = edge_det | pending;
        nxt_data  = 8'h80;
      end
      S_ADDR: begin
        load_byte = byte_done;
        nxt_data  = char_byte(str_q, 2'd0);
        nxt_rs    = 1'b1;
      end
      S_CHAR: begin
        load_byte = byte_done && (idx != 2'd3);
        nxt_data  = char_byte(str_q, idx + 2'd1);
        nxt_rs    = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only; later
  // assignments in this block deliberately override earlier ones (byte load
  // and end-of-sequence win over the byte counter).
  always_ff @(posedge clk_in) begin
    if (i_rst) begin
      state    <= S_PWRUP;
      wstate   <= W_IDLE;
      cnt      <= '0;
      idx      <= '0;
      str_q    <= '0;
      pend_q   <= '0;
      pending  <= 1'b0;
      valid_q  <= 1'b0;
      lcd_data <= 8'h00;
      lcd_rs   <= 1'b0;
      lcd_en   <= 1'b0;
      busy     <= 1'b1;
      ready    <= 1'b0;
    end else begin
      valid_q <= placar_valid;
      if (edge_det && state != S_IDLE) begin
        pending <= 1'b1;
        pend_q  <= placar_in;
      end

      case (wstate)
        W_SETUP:
          if (cnt == SETUP_LAST) begin
            wstate <= W_PULSE;
            cnt    <= '0;
            lcd_en <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        W_PULSE:
          if (cnt == EN_LAST) begin
            wstate <= W_HOLD;
            cnt    <= '0;
            lcd_en <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        W_HOLD:
          if (!byte_done) cnt <= cnt + 1'b1;
        default: ;
      endcase

      case (state)
        S_PWRUP:
          if (load_byte) begin
            state <= S_INIT;
            idx   <= 2'd0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        S_INIT:
          if (byte_done) begin
            if (idx == 2'd3) begin
              state <= S_IDLE;
              ready <= 1'b1;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        S_IDLE:
          if (load_byte) begin
            str_q   <= edge_det ? placar_in : pend_q;
            pending <= 1'b0;
            busy    <= 1'b1;
            state   <= S_ADDR;
          end
        S_ADDR:
          if (byte_done) begin
            state <= S_CHAR;
            idx   <= 2'd0;
          end
        S_CHAR:
          if (byte_done) begin
            if (idx == 2'd3) state <= S_IDLE;
            else             idx   <= idx + 2'd1;
          end
        default: state <= S_PWRUP;
      endcase

      if (load_byte) begin
        lcd_data <= nxt_data;
        lcd_rs   <= nxt_rs;
        wstate   <= W_SETUP;
        cnt      <= '0;
      end
      // A queued update keeps busy high straight into the next transaction.
      if (last_done) begin
        wstate <= W_IDLE;
        cnt    <= '0;
        busy   <= pending | edge_det;
      end
    end
  end

endmodule

// File: doc/lcd_placar_writer.md
Name: lcd_placar_writer

Overview:
- Downstream consumer of the Pong ball/score stage.
- Takes the 4-character score string and its update strobe, and drives a HD44780-compatible character LCD in 8-bit, write-only mode.
- Performs the LCD power-up init sequence itself, then writes the string to line 1, columns 0-3, on every new strobe.
- Provides busy/ready status and a single-entry pending slot, so score updates during a write are never lost.

Parameters:
- T_PWRUP, 750000, cycles waited after reset before the first init command (15 ms at 50 MHz).
- T_SETUP, 2, cycles lcd_rs/lcd_data are stable before lcd_en rises.
- T_EN, 25, cycles lcd_en is held high (500 ns).
- T_CMD, 2000, cycles waited after lcd_en falls for every byte except Clear (40 us).
- T_CLEAR, 82000, cycles waited after lcd_en falls for Clear (0x01) (1.64 ms).

Ports:
- clk_in  input  1  system clock, 50 MHz
- i_rst  input  1  synchronous reset, active-high
- placar_in  input  32  score string, byte3 (bits 31:24) first … byte0 (bits 7:0) last, ASCII
- placar_valid  input  1  update strobe, level; only its rising edge counts
- lcd_data  output  8  LCD DB7..DB0
- lcd_rs  output  1  0 = command, 1 = data
- lcd_rw  output  1  constant 0 (write only)
- lcd_en  output  1  LCD enable strobe
- busy  output  1  high while init runs or a string write is in progress
- ready  output  1  high once the init sequence has completed

Behaviour:
- Single clock domain clk_in. i_rst is synchronous and active-high; it is sampled on the rising edge of clk_in and overrides everything else.
- Reset values: lcd_data=0x00, lcd_rs=0, lcd_rw=0, lcd_en=0, busy=1, ready=0, pending=0, valid_q=0. Top FSM = S_PWRUP, byte FSM = W_IDLE.
- Edge detect: edge = placar_valid & ~valid_q, where valid_q is placar_valid registered. A strobe held high for N cycles yields exactly one edge.
- Byte write sub-FSM, common to all bytes:
  - W_SETUP: T_SETUP cycles, lcd_en=0.
  - W_PULSE: T_EN cycles, lcd_en=1.
  - W_HOLD: T_CMD cycles, or T_CLEAR if the byte is command 0x01, lcd_en=0.
  - lcd_rs and lcd_data are loaded on entry to W_SETUP and held unchanged until W_HOLD ends.
  - Cost per byte = T_SETUP+T_EN+T_WAIT cycles.
- Top FSM:
  - S_PWRUP: count T_PWRUP cycles, then go to S_INIT.
  - S_INIT: write commands (rs=0) 0x38, 0x0C, 0x06, 0x01 in order. After the last hold completes, set ready=1 and go to S_IDLE; busy drops to 0 in the same cycle unless pending=1.
  - S_IDLE: busy=0. On edge, or if pending=1: latch placar_in (or the pending value) into str_q, clear pending, set busy=1 on the next cycle, go to S_ADDR.
  - S_ADDR: write command 0x80 (DDRAM address 0), rs=0.
  - S_CHAR: write str_q byte3, byte2, byte1, byte0 with rs=1. Any byte equal to 0x00 is replaced by 0x20 (space). After byte0's hold, return to S_IDLE.
- Pending slot, single depth, newest wins:
  - An edge in any state other than S_IDLE (including S_PWRUP/S_INIT) sets pending=1 and captures placar_in into pend_q.
  - A later edge before service overwrites pend_q.
  - In S_IDLE, pending is serviced immediately. busy stays 1 across the back-to-back transition, with no idle cycle having busy=0.
- str_q is frozen for the whole transaction; placar_in changes during a write have no effect unless accompanied by an edge (which goes to the pending slot).
- Reset mid-operation: on the next edge of clk_in, lcd_en=0, ready=0, busy=1, pending cleared, and the full init restarts from S_PWRUP.
- All counters are wide enough for T_CLEAR and T_PWRUP; they are zeroed on every state entry and never wrap.

Test Plan:
Bench parameters: T_PWRUP=100, T_SETUP=2, T_EN=4, T_CMD=20, T_CLEAR=50.
1. Release reset, no strobe -> exactly 4 lcd_en pulses, with lcd_data 0x38, 0x0C, 0x06, 0x01 and rs=0. ready rises and busy falls 234 cycles after reset release (100+3×26+56). lcd_rw stays 0 throughout.
2. After ready, placar_in=0x00312C30, placar_valid 0→1 -> busy=1 on the next cycle. lcd_en pulses carry 0x80 (rs=0), then 0x20, 0x31, 0x2C, 0x30 (rs=1). busy low again 130 cycles after it rose. Each lcd_en pulse is 4 cycles long with data stable ≥2 cycles before the rise.
3. placar_valid held high for 3 cycles, then low -> exactly one transaction of 5 lcd_en pulses.
4. During the transaction from test 2: edge with 0x00322C30, then edge with 0x00332C30 -> immediately after the first write, one more transaction writing 0x80, 0x20, 0x33, 0x2C, 0x30. busy never drops between the two transactions. No write of 0x32 occurs.
5. Edge with 0x00312C31 at cycle 50 after reset (during S_PWRUP) -> init completes unchanged, then the 0x31-ending string is written immediately, with busy never low in between.
6. Assert i_rst for 1 cycle while lcd_en=1 mid-string -> next cycle lcd_en=0, ready=0, busy=1. Pending is cleared. The init sequence from test 1 repeats, and no character writes occur afterwards without a new edge.
